fixed_point_multiplier_array: RTL and testbench
===============================================

// Module: fixed_point_multiplier_array
// PURPOSE
//  Generalised CHANNELS x TAPS fixed-point multiplier array for the conv datapath.
//  Each of CHANNELS lanes multiplies one shared activation vector (TAPS words) by its own weight vector.
//  Every product is rounded or truncated, then saturated back to bitsize.
//  Results leave through a 2-stage elastic pipeline with valid/ready backpressure and a saturation flag.
// PARAMETERS
//  bitsize   14  signed word width of data, weights and results
//  FRAC_BITS 7   fractional bits (Q(bitsize-FRAC_BITS).FRAC_BITS); must be >=1 and < bitsize
//  TAPS      27  words per activation vector (kernel taps, e.g. 3x3x3)
//  CHANNELS  16  output channels (lanes)
// PORTS
//  clk         in   1                        clock, rising edge
//  rst         in   1                        asynchronous, active-low reset
//  in_valid    in   1                        data_in/weights/rnd_mode valid
//  in_ready    out  1                        array can accept a beat
//  rnd_mode    in   1                        0 = truncate (floor), 1 = round half up
//  data_in     in   bitsize*TAPS             activations; word t at [t*bitsize +: bitsize]
//  weights     in   bitsize*TAPS*CHANNELS    lane c, tap t at [(c*TAPS+t)*bitsize +: bitsize]
//  out_valid   out  1                        Mult_result/sat_flag valid
//  out_ready   in   1                        downstream accepts a beat
//  Mult_result out  bitsize*TAPS*CHANNELS    same packing as weights
//  sat_flag    out  1                        >=1 product of this beat saturated
// BEHAVIOUR
//  - A beat transfers in when in_valid && in_ready and out when out_valid && out_ready.
//  - Stage 1 (S1) registers the full-width signed products (2*bitsize bits) and rnd_mode.
//  - Stage 2 (S2) registers the rounded, saturated results and sat_flag.
//  - Each stage has a valid bit v1/v2. S2 loads when !v2 || out_ready. S1 loads when !v1 || S2 loads.
//  - in_ready = !v1 || !v2 || out_ready (combinational; no in_valid->in_ready path).
//  - Latency is 2 cycles with no stall. Throughput is 1 beat/cycle while out_ready=1.
//  - Stall: while out_valid && !out_ready, Mult_result and sat_flag hold stable.
//  - Stall: with both stages full, in_ready=0 and no beat is lost or duplicated.
//  - Simultaneous in/out transfer on a full pipe: both stages advance in the same cycle.
//  - Arithmetic per lane/tap: p = $signed(d)*$signed(w), 2*bitsize bits.
//    rnd_mode=1: q = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS. rnd_mode=0: q = p >>> FRAC_BITS.
//    Do the add in 2*bitsize+1 bits so there is no wrap.
//  - Saturation: clamp q to [-2^(bitsize-1), 2^(bitsize-1)-1].
//    sat_flag = OR of all clamp events in the beat.
//  - Reset (rst=0, any time): v1=v2=0, out_valid=0, in_ready=1, Mult_result=0, sat_flag=0.
//    Any beat in flight is discarded. The first beat after reset release follows normal timing.
//  - Data registers load only on stage advance. Registers do not change when their valid bit is 0.
// STRUCTURE
//  - Shared package/include: rounding-mode encodings RND_TRUNC=1'b0, RND_HALF_UP=1'b1,
//    and localparam PROD_W = 2*bitsize.
//  - Sub-module fixed_point_mul_round_sat: one tap's multiply plus round/saturate slices,
//    generated CHANNELS*TAPS times.
//  - The top level owns the v1/v2 control, the stage enables and the sat_flag OR-reduce.
// TESTING (bitsize=14, FRAC_BITS=7, all taps/lanes identical unless stated)
//  1. d=128, w=128, rnd_mode=0, out_ready=1
//     -> every result 128, sat_flag=0, out_valid exactly 2 cycles after accept.
//  2. d=8191, w=8191 -> 8191 with sat_flag=1.
//     d=-8192, w=8191 -> -8192 with sat_flag=1.
//  3. d=1, w=64 -> 0 (rnd_mode=0) and 1 (rnd_mode=1).
//     d=-1, w=1 -> -1 (rnd_mode=0) and 0 (rnd_mode=1).
//  4. Stream 10 beats (d=k, w=128, k=1..10) with out_ready toggled randomly
//     -> outputs 1..10 in order, none lost or duplicated.
//     in_ready=0 only when both stages are full and out_ready=0.
//  5. Fill pipe, hold out_ready=0 for 5 cycles
//     -> Mult_result stable and in_ready=0; release -> 2 beats drain in 2 cycles.
//  6. Assert rst low mid-stream with 2 beats in flight
//     -> out_valid=0 and outputs 0 immediately (async); after release the next beat appears at latency 2.
//  Per-lane check: lane c weight = c+1, d=128 -> lane c result = c+1 (packing/ordering).

Source files
------------

// File: rtl/fixed_point_multiplier_array_pkg.sv
// Shared types and constants for the fixed-point multiplier array.
// Rounding-mode encodings, default geometry and product width.
package fixed_point_multiplier_array_pkg;

  localparam int BITSIZE      = 14;
  localparam int FRAC_BITS_DEF = 7;
  localparam int TAPS_DEF     = 27;
  localparam int CHANNELS_DEF = 16;
  localparam int PROD_W       = 2 * BITSIZE;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_e;

endpackage

// File: rtl/fixed_point_multiplier_array_if.sv
// Valid/ready bundle for the multiplier array.
// master: upstream/downstream side; slave: the array itself.
interface fixed_point_multiplier_array_if #(
  parameter int bitsize  = 14,
  parameter int TAPS     = 27,
  parameter int CHANNELS = 16
) ();

  logic                              in_valid;
  logic                              in_ready;
  logic                              rnd_mode;
  logic [bitsize*TAPS-1:0]           data_in;
  logic [bitsize*TAPS*CHANNELS-1:0]  weights;
  logic                              out_valid;
  logic                              out_ready;
  logic [bitsize*TAPS*CHANNELS-1:0]  Mult_result;
  logic                              sat_flag;

  modport master (
    output in_valid, rnd_mode, data_in, weights, out_ready,
    input  in_ready, out_valid, Mult_result, sat_flag
  );

  modport slave (
    input  in_valid, rnd_mode, data_in, weights, out_ready,
    output in_ready, out_valid, Mult_result, sat_flag
  );

endinterface

// File: rtl/fixed_point_mul_round_sat.sv
// One tap: signed multiply slice, then round/saturate slice.
// i_d,i_w -> o_prod ; i_prod,i_rnd -> o_res,o_sat (both combinational).
module fixed_point_mul_round_sat
  import fixed_point_multiplier_array_pkg::*;
#(
  parameter int bitsize   = BITSIZE,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int PW        = PROD_W
) (
  input  logic signed [bitsize-1:0] i_d,
  input  logic signed [bitsize-1:0] i_w,
  output logic signed [PW-1:0]      o_prod,
  input  logic signed [PW-1:0]      i_prod,
  input  logic                      i_rnd,
  output logic [bitsize-1:0]        o_res,
  output logic                      o_sat
);

  localparam logic [PW:0] HALF =
    {{PW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [PW:0] MAXV =
    {{(PW-bitsize+2){1'b0}}, {(bitsize-1){1'b1}}};
  localparam logic signed [PW:0] MINV =
    {{(PW-bitsize+2){1'b1}}, {(bitsize-1){1'b0}}};

  logic signed [PW:0] w_sum;
  logic signed [PW:0] w_q;

  assign o_prod = i_d * i_w;

  // One extra bit keeps the rounding add from wrapping.
  assign w_sum = {i_prod[PW-1], i_prod}
               + ((i_rnd == RND_HALF_UP) ? HALF : '0);
  assign w_q = w_sum >>> FRAC_BITS;

  always_comb begin
    o_sat = 1'b0;
    o_res = w_q[bitsize-1:0];
    if (w_q > MAXV) begin
      o_sat = 1'b1;
      o_res = MAXV[bitsize-1:0];
    end else if (w_q < MINV) begin
      o_sat = 1'b1;
      o_res = MINV[bitsize-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_multiplier_array.sv
// CHANNELS x TAPS fixed-point multiplier array, 2-stage elastic pipe.
// clk, rst (async active-low), bus (slave side of the valid/ready bundle).
module fixed_point_multiplier_array
  import fixed_point_multiplier_array_pkg::*;
#(
  parameter int bitsize   = BITSIZE,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int TAPS      = TAPS_DEF,
  parameter int CHANNELS  = CHANNELS_DEF
) (
  input logic                        clk,
  input logic                        rst,
  fixed_point_multiplier_array_if.slave bus
);

  localparam int PW = 2 * bitsize;
  localparam int N  = CHANNELS * TAPS;

  logic signed [PW-1:0] w_prod [N];
  logic signed [PW-1:0] r_prod [N];
  logic [N-1:0]         w_sat;
  logic [bitsize*N-1:0] w_res;
  logic [bitsize*N-1:0] r_res;
  logic r_v1, r_v2, r_rnd, r_sat;
  logic w_s1_en, w_s2_en;

  assign w_s2_en = !r_v2 || bus.out_ready;
  assign w_s1_en = !r_v1 || w_s2_en;

  assign bus.in_ready    = w_s1_en;
  assign bus.out_valid   = r_v2;
  assign bus.Mult_result = r_res;
  assign bus.sat_flag    = r_sat;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      localparam int I = c * TAPS + t;
      fixed_point_mul_round_sat #(
        .bitsize  (bitsize),
        .FRAC_BITS(FRAC_BITS),
        .PW       (PW)
      ) u_tap (
        .i_d   (bus.data_in[t*bitsize +: bitsize]),
        .i_w   (bus.weights[I*bitsize +: bitsize]),
        .o_prod(w_prod[I]),
        .i_prod(r_prod[I]),
        .i_rnd (r_rnd),
        .o_res (w_res[I*bitsize +: bitsize]),
        .o_sat (w_sat[I])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_rnd <= 1'b0;
      for (int i = 0; i < N; i++) r_prod[i] <= '0;
    end else if (w_s1_en) begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_rnd  <= bus.rnd_mode;
        r_prod <= w_prod;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2  <= 1'b0;
      r_res <= '0;
      r_sat <= 1'b0;
    end else if (w_s2_en) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_res <= w_res;
        r_sat <= |w_sat;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_multiplier_array.sv
// Directed bench for fixed_point_multiplier_array.
// Hand-computed vectors, stall/stream/reset scenarios, one check task.
module tb_fixed_point_multiplier_array;

  localparam int BS = 14;
  localparam int T  = 27;
  localparam int C  = 16;
  localparam int N  = T * C;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fixed_point_multiplier_array_if #(
    .bitsize(BS), .TAPS(T), .CHANNELS(C)
  ) bus ();

  fixed_point_multiplier_array #(
    .bitsize(BS), .FRAC_BITS(7), .TAPS(T), .CHANNELS(C)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  function automatic logic [BS*T-1:0] mk_d(int v);
    logic [BS*T-1:0] r;
    for (int t = 0; t < T; t++) r[t*BS +: BS] = v[BS-1:0];
    return r;
  endfunction

  function automatic logic [BS*N-1:0] mk_w(int v);
    logic [BS*N-1:0] r;
    for (int i = 0; i < N; i++) r[i*BS +: BS] = v[BS-1:0];
    return r;
  endfunction

  function automatic logic [BS*N-1:0] mk_w_lane();
    logic [BS*N-1:0] r;
    int v;
    for (int i = 0; i < N; i++) begin
      v = i / T + 1;
      r[i*BS +: BS] = v[BS-1:0];
    end
    return r;
  endfunction

  function automatic int word(int i);
    return int'($signed(bus.Mult_result[i*BS +: BS]));
  endfunction

  function automatic int n_bad(int e);
    int b = 0;
    for (int i = 0; i < N; i++) if (word(i) != e) b++;
    return b;
  endfunction

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(string tag, int d, int w,
                          logic rnd, int exp, int esat);
    bus.in_valid  = 1'b1;
    bus.data_in   = mk_d(d);
    bus.weights   = mk_w(w);
    bus.rnd_mode  = rnd;
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, int'(bus.out_valid), 0);
    tick();
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_w0"}, word(0), exp);
    check({tag, "_all"}, n_bad(exp), 0);
    check({tag, "_sat"}, int'(bus.sat_flag), esat);
    tick();
  endtask

  initial begin
    int sent, recv, occ;
    logic acc, take;
    bus.in_valid  = 1'b0;
    bus.rnd_mode  = 1'b0;
    bus.data_in   = '0;
    bus.weights   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("rst_ov", int'(bus.out_valid), 0);
    check("rst_ir", int'(bus.in_ready), 1);
    check("rst_sat", int'(bus.sat_flag), 0);
    check("rst_res", n_bad(0), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    run_beat("unit", 128, 128, 1'b0, 128, 0);
    run_beat("satp", 8191, 8191, 1'b0, 8191, 1);
    run_beat("satn", -8192, 8191, 1'b0, -8192, 1);
    run_beat("tr_pos", 1, 64, 1'b0, 0, 0);
    run_beat("rd_pos", 1, 64, 1'b1, 1, 0);
    run_beat("tr_neg", -1, 1, 1'b0, -1, 0);
    run_beat("rd_neg", -1, 1, 1'b1, 0, 0);

    bus.in_valid = 1'b1;
    bus.data_in  = mk_d(128);
    bus.weights  = mk_w_lane();
    bus.rnd_mode = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    for (int c = 0; c < C; c++)
      check($sformatf("lane%0d", c), word(c*T + (c % T)), c + 1);
    tick();

    sent = 0; recv = 0; occ = 0;
    bus.weights = mk_w(128);
    for (int cyc = 0; cyc < 300 && recv < 10; cyc++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = (sent < 10);
      bus.data_in   = mk_d(sent + 1);
      #1;
      check("s_ready", int'(bus.in_ready),
            int'(!(occ == 2 && !bus.out_ready)));
      acc  = bus.in_valid && bus.in_ready;
      take = bus.out_valid && bus.out_ready;
      if (take) begin
        check("s_data", word(0), recv + 1);
        check("s_all", n_bad(recv + 1), 0);
        recv++;
      end
      tick();
      if (acc) sent++;
      occ = occ + int'(acc) - int'(take);
    end
    bus.in_valid = 1'b0;
    check("s_count", recv, 10);
    check("s_empty", int'(bus.out_valid), 0);

    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = mk_d(3);
    tick();
    bus.data_in = mk_d(4);
    tick();
    bus.data_in = mk_d(5);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("st_ir", int'(bus.in_ready), 0);
      check("st_ov", int'(bus.out_valid), 1);
      check("st_res", word(0), 3);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("dr_1", word(0), 3);
    tick();
    check("dr_2v", int'(bus.out_valid), 1);
    check("dr_2", word(0), 4);
    tick();
    check("dr_end", int'(bus.out_valid), 0);

    bus.in_valid = 1'b1;
    bus.data_in  = mk_d(9);
    tick();
    bus.data_in = mk_d(10);
    tick();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("ar_ov", int'(bus.out_valid), 0);
    check("ar_res", n_bad(0), 0);
    check("ar_sat", int'(bus.sat_flag), 0);
    check("ar_ir", int'(bus.in_ready), 1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ar_drop", int'(bus.out_valid), 0);
    run_beat("ar_next", 7, 128, 1'b0, 7, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
